// File: rtl/axi_ar_rr_arbiter.sv
// Round-robin AXI read-address arbiter with ID prefixing, R-channel routing and
// per-master outstanding-burst limiting. Define AXI_AR_ARB_STALL_CNT_EN for per-master stall counters.
module axi_ar_rr_arbiter #(
    parameter int NB_MASTER       = 3,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ID_IN_WIDTH = 2,
    parameter int IDX_WIDTH       = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NB_MASTER-1:0]                     m_arvalid_i,
    output logic [NB_MASTER-1:0]                     m_arready_o,
    input  logic [NB_MASTER*AXI_ADDR_WIDTH-1:0]      m_araddr_i,
    input  logic [NB_MASTER*AXI_ID_IN_WIDTH-1:0]     m_arid_i,
    input  logic [NB_MASTER*8-1:0]                   m_arlen_i,
    output logic                                     s_arvalid_o,
    input  logic                                     s_arready_i,
    output logic [AXI_ADDR_WIDTH-1:0]                s_araddr_o,
    output logic [IDX_WIDTH+AXI_ID_IN_WIDTH-1:0]     s_arid_o,
    output logic [7:0]                               s_arlen_o,
    input  logic                                     s_rvalid_i,
    output logic                                     s_rready_o,
    input  logic [IDX_WIDTH+AXI_ID_IN_WIDTH-1:0]     s_rid_i,
    input  logic [AXI_DATA_WIDTH-1:0]                s_rdata_i,
    input  logic                                     s_rlast_i,
    output logic [NB_MASTER-1:0]                     m_rvalid_o,
    input  logic [NB_MASTER-1:0]                     m_rready_i,
    output logic [AXI_ID_IN_WIDTH-1:0]               m_rid_o,
    output logic [AXI_DATA_WIDTH-1:0]                m_rdata_o,
    output logic                                     m_rlast_o,
`ifdef AXI_AR_ARB_STALL_CNT_EN
    output logic [NB_MASTER*16-1:0]                  stall_cnt_o,
`endif
    output logic                                     err_o
);

    localparam int         SID_W   = IDX_WIDTH + AXI_ID_IN_WIDTH;
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                     state_q, state_d;
    logic [IDX_WIDTH-1:0]       ptr_q, ptr_d;
    logic [AXI_ADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic [SID_W-1:0]           arid_q, arid_d;
    logic [7:0]                 arlen_q, arlen_d;
    logic [3:0]                 cnt_q [NB_MASTER];
    logic [3:0]                 cnt_d [NB_MASTER];
    logic                       err_q, err_d;

    logic [NB_MASTER-1:0]       eligible;
    logic                       gnt_found;
    logic [IDX_WIDTH-1:0]       gnt_idx;
    logic [IDX_WIDTH-1:0]       r_idx;
    logic                       r_idx_ok;
    logic                       r_last_hs;
    logic                       issue_hs;

    always_comb begin
        for (int i = 0; i < NB_MASTER; i++) begin
            eligible[i] = m_arvalid_i[i] && (cnt_q[i] < MAX_OUT);
        end
    end

    // First eligible master at distance 1..NB_MASTER from the last winner.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NB_MASTER; k++) begin
            for (int i = 0; i < NB_MASTER; i++) begin
                if (!gnt_found && eligible[i] && (((int'(ptr_q) + k) % NB_MASTER) == i)) begin
                    gnt_found = 1'b1;
                    gnt_idx   = IDX_WIDTH'(i);
                end
            end
        end
    end

    // Next-state and AR capture.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        araddr_d = araddr_q;
        arid_d   = arid_q;
        arlen_d  = arlen_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    state_d = ISSUE;
                    ptr_d   = gnt_idx;
                    for (int i = 0; i < NB_MASTER; i++) begin
                        if (gnt_idx == IDX_WIDTH'(i)) begin
                            araddr_d = m_araddr_i[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                            arid_d   = {gnt_idx, m_arid_i[i*AXI_ID_IN_WIDTH +: AXI_ID_IN_WIDTH]};
                            arlen_d  = m_arlen_i[i*8 +: 8];
                        end
                    end
                end
            end
            ISSUE: begin
                if (s_arready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the grant is held off while rst is high.
    always_comb begin
        m_arready_o = '0;
        s_arvalid_o = (state_q == ISSUE);
        if (!rst && (state_q == IDLE) && gnt_found) begin
            for (int i = 0; i < NB_MASTER; i++) begin
                m_arready_o[i] = (gnt_idx == IDX_WIDTH'(i));
            end
        end
    end

    assign s_araddr_o = araddr_q;
    assign s_arid_o   = arid_q;
    assign s_arlen_o  = arlen_q;

    // R routing by ID prefix; beats with an unknown prefix are accepted and dropped.
    assign r_idx     = s_rid_i[SID_W-1 -: IDX_WIDTH];
    assign r_idx_ok  = (int'(r_idx) < NB_MASTER);
    assign m_rid_o   = s_rid_i[AXI_ID_IN_WIDTH-1:0];
    assign m_rdata_o = s_rdata_i;
    assign m_rlast_o = s_rlast_i;

    always_comb begin
        m_rvalid_o = '0;
        s_rready_o = !r_idx_ok;
        for (int i = 0; i < NB_MASTER; i++) begin
            if (r_idx == IDX_WIDTH'(i)) begin
                m_rvalid_o[i] = s_rvalid_i;
                s_rready_o    = m_rready_i[i];
            end
        end
    end

    assign issue_hs  = (state_q == ISSUE) && s_arready_i;
    assign r_last_hs = s_rvalid_i && s_rready_o && s_rlast_i && r_idx_ok;

    always_comb begin
        err_d = err_q || (s_rvalid_i && !r_idx_ok);
        for (int i = 0; i < NB_MASTER; i++) begin
            logic inc, dec;
            inc = issue_hs && (ptr_q == IDX_WIDTH'(i));
            dec = r_last_hs && (r_idx == IDX_WIDTH'(i));
            if (dec && (cnt_q[i] == 4'd0)) err_d = 1'b1;
            unique case ({inc, dec})
                2'b10:   cnt_d[i] = cnt_q[i] + 4'd1;
                2'b01:   cnt_d[i] = (cnt_q[i] == 4'd0) ? 4'd0 : cnt_q[i] - 4'd1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    assign err_o = err_q;

    always_ff @(posedge clk) begin
        // NOTE: the counter array is reset along with the control state; a stale count would block a master forever.
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= IDX_WIDTH'(NB_MASTER - 1);
            araddr_q <= '0;
            arid_q   <= '0;
            arlen_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < NB_MASTER; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            araddr_q <= araddr_d;
            arid_q   <= arid_d;
            arlen_q  <= arlen_d;
            err_q    <= err_d;
            for (int i = 0; i < NB_MASTER; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef AXI_AR_ARB_STALL_CNT_EN
    logic [15:0] stall_q [NB_MASTER];
    logic [15:0] stall_d [NB_MASTER];

    always_comb begin
        for (int i = 0; i < NB_MASTER; i++) begin
            stall_d[i] = stall_q[i];
            if (m_arvalid_i[i] && !m_arready_o[i] && (stall_q[i] != 16'hFFFF))
                stall_d[i] = stall_q[i] + 16'd1;
            stall_cnt_o[i*16 +: 16] = stall_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NB_MASTER; i++) stall_q[i] <= '0;
        end else begin
            for (int i = 0; i < NB_MASTER; i++) stall_q[i] <= stall_d[i];
        end
    end
`endif

endmodule

// File: doc/axi_ar_rr_arbiter.md
Name: axi_ar_rr_arbiter

Overview:
- Round-robin arbiter for the AXI read-address (AR) channel. Shares one AXI slave-side AR/R port between NB_MASTER requesters: core, debug and SPI-slave bridge.
- Prefixes the winning master index onto ARID, so 2-bit master IDs become 4-bit slave IDs. Routes R beats back to the issuing master by that prefix.
- Limits outstanding bursts per master.
- Sits between the requesters and one slave port of the interconnect: memory or the peripheral bridge.

Parameters:
- NB_MASTER, 3, number of requesters (2..4)
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 32, R data width
- AXI_ID_IN_WIDTH, 2, master-side ID width
- IDX_WIDTH, 2, prefix width; must satisfy 2**IDX_WIDTH >= NB_MASTER
- MAX_OUTSTANDING, 4, max in-flight bursts per master (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_arvalid_i  in  NB_MASTER  per-master AR valid
- m_arready_o  out  NB_MASTER  per-master AR ready
- m_araddr_i  in  NB_MASTER x AXI_ADDR_WIDTH  per-master address
- m_arid_i  in  NB_MASTER x AXI_ID_IN_WIDTH  per-master ID
- m_arlen_i  in  NB_MASTER x 8  per-master burst length
- s_arvalid_o  out  1  slave AR valid
- s_arready_i  in  1  slave AR ready
- s_araddr_o  out  AXI_ADDR_WIDTH  slave address
- s_arid_o  out  IDX_WIDTH+AXI_ID_IN_WIDTH  {master index, master ID}
- s_arlen_o  out  8  slave burst length
- s_rvalid_i  in  1  slave R valid
- s_rready_o  out  1  slave R ready
- s_rid_i  in  IDX_WIDTH+AXI_ID_IN_WIDTH  R ID
- s_rdata_i  in  AXI_DATA_WIDTH  R data
- s_rlast_i  in  1  R last
- m_rvalid_o  out  NB_MASTER  per-master R valid
- m_rready_i  in  NB_MASTER  per-master R ready
- m_rid_o  out  AXI_ID_IN_WIDTH  s_rid_i low bits, broadcast
- m_rdata_o  out  AXI_DATA_WIDTH  broadcast R data
- m_rlast_o  out  1  broadcast R last
- err_o  out  1  sticky protocol-error flag

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - FSM goes to IDLE.
  - s_arvalid_o=0; s_araddr_o/s_arid_o/s_arlen_o=0.
  - Round-robin pointer = NB_MASTER-1, so master 0 has first priority.
  - All outstanding counters = 0; err_o=0.
  - m_arready_o=0 while rst is high.
- Eligibility: master i is eligible when m_arvalid_i[i]=1 and cnt[i] < MAX_OUTSTANDING.
- FSM IDLE:
  - Grant the first eligible master scanning from ptr+1 upward, wrapping modulo NB_MASTER.
  - Combinationally assert m_arready_o[g] for that master in the same cycle.
  - On that edge: register addr/len and {g, id} into the output register; ptr<=g; go to ISSUE.
  - No eligible master: stay in IDLE, all m_arready_o=0.
- FSM ISSUE:
  - s_arvalid_o=1; all m_arready_o=0.
  - Output register holds stable until s_arready_i=1; on that edge: cnt[g]++, go to IDLE.
- AR throughput: at most one AR per 2 cycles. AR latency from master handshake to s_arvalid_o is 1 cycle.
- R routing (combinational, no storage):
  - idx = s_rid_i[top IDX_WIDTH bits].
  - m_rvalid_o[idx]=s_rvalid_i; all other m_rvalid_o=0.
  - s_rready_o=m_rready_i[idx].
- Counter decrement: on s_rvalid_i && s_rready_o && s_rlast_i, cnt[idx]--.
- Simultaneous increment and decrement of the same counter in one cycle: net unchanged.
- Error cases (err_o set, cleared only by rst):
  - idx >= NB_MASTER: s_rready_o=1, beat dropped, all m_rvalid_o=0, err_o<=1.
  - Decrement when cnt=0: counter stays 0, err_o<=1.
- Counter never exceeds MAX_OUTSTANDING, because eligibility gating prevents it.
- Reset asserted mid-ISSUE: pending AR is abandoned, s_arvalid_o=0 the next cycle, counters cleared. In-flight R beats after reset are treated per the decrement rule and flag err_o.

Optional Feature:
- Macro: AXI_AR_ARB_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o, NB_MASTER x 16.
  - stall_cnt_o[i] increments each cycle m_arvalid_i[i]=1 and m_arready_o[i]=0, saturating at 16'hFFFF.
  - Reset value 0.
- When undefined: port absent, no counters synthesized. All other behaviour identical.

Test Plan:
- Single master: m0 arvalid, addr=0x0010_0040, id=1, len=3, s_arready tied 1 -> m_arready_o[0] at cycle 0; s_arvalid_o at cycle 1 with s_arid_o=4'b0001, s_arlen_o=3; cnt[0]=1.
- Round-robin: all three masters valid continuously, slave always ready -> grant order 0,1,2,0,1,2; s_arid_o prefixes 0,1,2 repeating, one AR every 2 cycles.
- Outstanding limit: master 1 issues 4 ARs, no R returned -> 5th request stalls (m_arready_o[1]=0) while master 2 still gets granted. One R beat with rid=4'b0110, rlast=1 -> master 1 granted within 2 cycles.
- R routing: s_rvalid with rid=4'b1011, data=0xDEADBEEF, m_rready_i[2]=0 -> m_rvalid_o=3'b100, s_rready_o=0; raising m_rready_i[2] completes the beat, m_rid_o=2'b11.
- Errors: rid prefix 3 with NB_MASTER=3 -> s_rready_o=1, m_rvalid_o=0, err_o=1 sticky. Separately, rlast for a master with cnt=0 -> err_o=1. rst clears err_o.
- Reset mid-ISSUE with s_arready_i=0 -> s_arvalid_o=0 next cycle, all counters 0. With AXI_AR_ARB_STALL_CNT_EN, master 0 held off 10 cycles -> stall_cnt_o[0]=10.
